// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: S memory geometry and the PRGA state encoding.
// Used by the key-scheduling FSM, the PRGA/decrypt stage and the top-level S ownership mux.
package rc4_pkg;

    localparam int S_DEPTH  = 256;
    localparam int S_ADDR_W = 8;

    typedef enum logic [3:0] {
        PRGA_IDLE,
        PRGA_READ_SI,
        PRGA_WAIT_SI,
        PRGA_READ_SJ,
        PRGA_WAIT_SJ,
        PRGA_WRITE_SI,
        PRGA_WRITE_SJ,
        PRGA_READ_F,
        PRGA_WAIT_F,
        PRGA_WRITE_OUT,
        PRGA_DONE
    } prga_state_t;

endpackage

// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA + decrypt: walks S for one keystream byte per message byte, XORs it with the ROM byte into RAM.
// Latency 9 cycles/byte (done 9*MSG_LENGTH cycles after start); no backpressure, memories always ready.
module rc4_prga_decrypt
    import rc4_pkg::*;
#(
    parameter int MSG_LENGTH = 32,
    parameter int MSG_ADDR_W = 5
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  start,
    output logic [S_ADDR_W-1:0]   s_address,
    output logic [7:0]            s_data,
    output logic                  s_wren,
    input  logic [7:0]            s_q,
    output logic [MSG_ADDR_W-1:0] rom_address,
    input  logic [7:0]            rom_q,
    output logic [MSG_ADDR_W-1:0] ram_address,
    output logic [7:0]            ram_data,
    output logic                  ram_wren,
    output logic                  busy,
    output logic                  done
);

    localparam logic [MSG_ADDR_W:0] K_ONE  = (MSG_ADDR_W+1)'(1);
    localparam logic [MSG_ADDR_W:0] LAST_K = (MSG_ADDR_W+1)'(MSG_LENGTH - 1);

    prga_state_t state, state_nxt;

    logic [S_ADDR_W-1:0]   i, i_nxt;
    logic [S_ADDR_W-1:0]   j, j_nxt;
    logic [7:0]            si, si_nxt;
    logic [7:0]            sj, sj_nxt;
    logic [MSG_ADDR_W:0]   k, k_nxt;

    logic [S_ADDR_W-1:0]   s_address_nxt;
    logic [7:0]            s_data_nxt;
    logic                  s_wren_nxt;
    logic [MSG_ADDR_W-1:0] rom_address_nxt;
    logic [MSG_ADDR_W-1:0] ram_address_nxt;
    logic [7:0]            ram_data_nxt;
    logic                  ram_wren_nxt;
    logic                  busy_nxt;
    logic                  done_nxt;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= PRGA_IDLE;
            i           <= '0;
            j           <= '0;
            si          <= '0;
            sj          <= '0;
            k           <= '0;
            s_address   <= '0;
            s_data      <= '0;
            s_wren      <= 1'b0;
            rom_address <= '0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            i           <= i_nxt;
            j           <= j_nxt;
            si          <= si_nxt;
            sj          <= sj_nxt;
            k           <= k_nxt;
            s_address   <= s_address_nxt;
            s_data      <= s_data_nxt;
            s_wren      <= s_wren_nxt;
            rom_address <= rom_address_nxt;
            ram_address <= ram_address_nxt;
            ram_data    <= ram_data_nxt;
            ram_wren    <= ram_wren_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        i_nxt           = i;
        j_nxt           = j;
        si_nxt          = si;
        sj_nxt          = sj;
        k_nxt           = k;
        s_address_nxt   = s_address;
        s_data_nxt      = s_data;
        s_wren_nxt      = 1'b0;
        rom_address_nxt = rom_address;
        ram_address_nxt = ram_address;
        ram_data_nxt    = ram_data;
        ram_wren_nxt    = 1'b0;
        busy_nxt        = busy;
        done_nxt        = done;

        case (state)
            PRGA_IDLE: begin
                if (start) begin
                    busy_nxt  = 1'b1;
                    state_nxt = PRGA_READ_SI;
                end
            end
            PRGA_READ_SI: begin
                i_nxt         = i + 8'd1;
                s_address_nxt = i + 8'd1;
                state_nxt     = PRGA_WAIT_SI;
            end
            PRGA_WAIT_SI: state_nxt = PRGA_READ_SJ;
            PRGA_READ_SJ: begin
                si_nxt        = s_q;
                j_nxt         = j + s_q;
                s_address_nxt = j + s_q;
                state_nxt     = PRGA_WAIT_SJ;
            end
            PRGA_WAIT_SJ: state_nxt = PRGA_WRITE_SI;
            // S[i] is written before S[j]; when i==j both carry the same byte, so S stays intact.
            PRGA_WRITE_SI: begin
                sj_nxt        = s_q;
                s_address_nxt = i;
                s_data_nxt    = s_q;
                s_wren_nxt    = 1'b1;
                state_nxt     = PRGA_WRITE_SJ;
            end
            PRGA_WRITE_SJ: begin
                s_address_nxt = j;
                s_data_nxt    = si;
                s_wren_nxt    = 1'b1;
                state_nxt     = PRGA_READ_F;
            end
            PRGA_READ_F: begin
                s_address_nxt   = si + sj;
                rom_address_nxt = k[MSG_ADDR_W-1:0];
                state_nxt       = PRGA_WAIT_F;
            end
            PRGA_WAIT_F: state_nxt = PRGA_WRITE_OUT;
            PRGA_WRITE_OUT: begin
                ram_address_nxt = k[MSG_ADDR_W-1:0];
                ram_data_nxt    = s_q ^ rom_q;
                ram_wren_nxt    = 1'b1;
                k_nxt           = k + K_ONE;
                if (k == LAST_K) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = PRGA_DONE;
                end else begin
                    state_nxt = PRGA_READ_SI;
                end
            end
            PRGA_DONE: begin
                if (start) begin
                    i_nxt     = '0;
                    j_nxt     = '0;
                    k_nxt     = '0;
                    done_nxt  = 1'b0;
                    state_nxt = PRGA_IDLE;
                end
            end
            default: state_nxt = PRGA_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Directed bench for rc4_prga_decrypt: default-size instance plus a 300-byte instance, each with S/ROM/RAM models.
// Expected bytes come from hand-derived constants and a software RC4 reference.
module tb_rc4_prga_decrypt;

    logic CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    logic reset, start_a, start_b;

    logic [7:0] s_address_a, s_data_a, s_q_a, rom_q_a, ram_data_a;
    logic       s_wren_a, ram_wren_a, busy_a, done_a;
    logic [4:0] rom_address_a, ram_address_a;

    logic [7:0] s_address_b, s_data_b, s_q_b, rom_q_b, ram_data_b;
    logic       s_wren_b, ram_wren_b, busy_b, done_b;
    logic [8:0] rom_address_b, ram_address_b;

    logic [7:0] s_mem_a [256];
    logic [7:0] s_mem_b [256];
    logic [7:0] ram_a   [32];
    logic [7:0] ram_b   [512];
    logic [7:0] rom_img [512];
    logic [7:0] s_ref   [256];
    logic [7:0] exp_dec [512];
    logic       pl_a, pl_b, clr_a, clr_b, sel;

    int n_vec, n_err;
    int cyc, wr_cnt, ord_err, sw_n;
    logic [7:0] sw_addr [2];
    logic [7:0] sw_dat  [2];
    logic [7:0] snap3, snap5;

    rc4_prga_decrypt dut_a (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start_a),
        .s_address(s_address_a), .s_data(s_data_a), .s_wren(s_wren_a), .s_q(s_q_a),
        .rom_address(rom_address_a), .rom_q(rom_q_a),
        .ram_address(ram_address_a), .ram_data(ram_data_a), .ram_wren(ram_wren_a),
        .busy(busy_a), .done(done_a)
    );

    rc4_prga_decrypt #(.MSG_LENGTH(300), .MSG_ADDR_W(9)) dut_b (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start_b),
        .s_address(s_address_b), .s_data(s_data_b), .s_wren(s_wren_b), .s_q(s_q_b),
        .rom_address(rom_address_b), .rom_q(rom_q_b),
        .ram_address(ram_address_b), .ram_data(ram_data_b), .ram_wren(ram_wren_b),
        .busy(busy_b), .done(done_b)
    );

    always @(posedge CLOCK_50) begin
        if (pl_a) for (int x = 0; x < 256; x++) s_mem_a[x] <= s_ref[x];
        else if (s_wren_a) s_mem_a[s_address_a] <= s_data_a;
        s_q_a   <= s_mem_a[s_address_a];
        rom_q_a <= rom_img[{4'd0, rom_address_a}];
        if (clr_a) for (int x = 0; x < 32; x++) ram_a[x] <= 8'h00;
        if (ram_wren_a) ram_a[ram_address_a] <= ram_data_a;
    end

    always @(posedge CLOCK_50) begin
        if (pl_b) for (int y = 0; y < 256; y++) s_mem_b[y] <= s_ref[y];
        else if (s_wren_b) s_mem_b[s_address_b] <= s_data_b;
        s_q_b   <= s_mem_b[s_address_b];
        rom_q_b <= rom_img[rom_address_b];
        if (clr_b) for (int y = 0; y < 512; y++) ram_b[y] <= 8'h00;
        if (ram_wren_b) ram_b[ram_address_b] <= ram_data_b;
    end

    logic       m_s_wren, m_ram_wren, m_done;
    logic [7:0] m_s_address, m_s_data;
    logic [8:0] m_ram_address;
    assign m_s_wren      = sel ? s_wren_b    : s_wren_a;
    assign m_ram_wren    = sel ? ram_wren_b  : ram_wren_a;
    assign m_done        = sel ? done_b      : done_a;
    assign m_s_address   = sel ? s_address_b : s_address_a;
    assign m_s_data      = sel ? s_data_b    : s_data_a;
    assign m_ram_address = sel ? ram_address_b : {4'd0, ram_address_a};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_identity();
        for (int x = 0; x < 256; x++) s_ref[x] = 8'(x);
    endtask

    task automatic ksa(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2);
        logic [7:0] key [3];
        logic [7:0] jj, t;
        key[0] = k0; key[1] = k1; key[2] = k2;
        load_identity();
        jj = 8'd0;
        for (int x = 0; x < 256; x++) begin
            jj = jj + s_ref[x] + key[x % 3];
            t = s_ref[x]; s_ref[x] = s_ref[jj]; s_ref[jj] = t;
        end
    endtask

    task automatic ref_prga(input int n);
        logic [7:0] s [256];
        logic [7:0] ii, jj, t, fa;
        s = s_ref;
        ii = 8'd0; jj = 8'd0;
        for (int kk = 0; kk < n; kk++) begin
            ii = ii + 8'd1;
            jj = jj + s[ii];
            t = s[ii]; s[ii] = s[jj]; s[jj] = t;
            fa = s[ii] + s[jj];
            exp_dec[kk] = s[fa] ^ rom_img[kk];
        end
    endtask

    task automatic prep(input bit b, input bit clr);
        if (b) begin pl_b = 1'b1; clr_b = clr; end
        else   begin pl_a = 1'b1; clr_a = clr; end
        @(negedge CLOCK_50);
        pl_a = 1'b0; pl_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    endtask

    // Call at a negedge with start high and the selected DUT in IDLE; returns at the negedge where done is seen.
    task automatic run(input bit hold, input int budget);
        cyc = 0; wr_cnt = 0; ord_err = 0; sw_n = 0;
        @(posedge CLOCK_50);
        for (int t = 0; t <= budget; t++) begin
            @(negedge CLOCK_50);
            cyc = t;
            if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
            if (m_s_wren && sw_n < 2) begin
                sw_addr[sw_n] = m_s_address; sw_dat[sw_n] = m_s_data; sw_n++;
            end
            if (m_ram_wren) begin
                if (m_ram_address != 9'(wr_cnt)) ord_err++;
                wr_cnt++;
            end
            if (t == 27) begin snap3 = s_mem_a[3]; snap5 = s_mem_a[5]; end
            if (m_done) break;
            @(posedge CLOCK_50);
        end
    endtask

    task automatic cmp_ram_a(input string tag);
        for (int kk = 0; kk < 32; kk++)
            check($sformatf("%s%0d", tag, kk), 32'(ram_a[kk]), 32'(exp_dec[kk]));
    endtask

    initial begin
        int wr, mism;
        n_vec = 0; n_err = 0;
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
        pl_a = 1'b0; pl_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        for (int x = 0; x < 512; x++) rom_img[x] = 8'(x * 37 + 11);
        rom_img[0] = 8'hFF; rom_img[1] = 8'hFF; rom_img[2] = 8'hFF;
        repeat (3) @(negedge CLOCK_50);
        check("rst_ctl_a", 32'({busy_a, done_a, s_wren_a, ram_wren_a}), 0);
        check("rst_addr_a", 32'({s_address_a, s_data_a, rom_address_a, ram_address_a}), 0);
        check("rst_data_a", 32'(ram_data_a), 0);
        check("rst_ctl_b", 32'({busy_b, done_b, s_wren_b, ram_wren_b}), 0);
        reset = 1'b0;

        // Identity S, enc[0..2]=FF
        load_identity(); prep(0, 1); ref_prga(32);
        start_a = 1'b1;
        run(0, 400);
        check("id_done_cycle", 32'(cyc), 288);
        check("id_wr_count", 32'(wr_cnt), 32);
        check("id_wr_order", 32'(ord_err), 0);
        check("id_swr0", 32'({sw_addr[0], sw_dat[0]}), 'h0101);
        check("id_swr1", 32'({sw_addr[1], sw_dat[1]}), 'h0101);
        check("id_s3", 32'(snap3), 'h05);
        check("id_s5", 32'(snap5), 'h02);
        @(negedge CLOCK_50);
        check("id_ram0", 32'(ram_a[0]), 'hFD);
        check("id_ram1", 32'(ram_a[1]), 'hFA);
        check("id_ram2", 32'(ram_a[2]), 'hF8);
        check("id_busy_done", 32'({busy_a, done_a}), 'b01);
        cmp_ram_a("id_ram");

        // Key 00 02 49
        ksa(8'h00, 8'h02, 8'h49); prep(0, 1); ref_prga(32);
        start_a = 1'b1;
        @(negedge CLOCK_50);
        check("ksa_idle_done", 32'(done_a), 0);
        run(0, 400);
        check("ksa_done_cycle", 32'(cyc), 288);
        @(negedge CLOCK_50);
        cmp_ram_a("ksa_ram");

        // Reset at cycle 100 then rerun
        prep(0, 1);
        start_a = 1'b1;
        @(negedge CLOCK_50);
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        start_a = 1'b0;
        repeat (99) @(negedge CLOCK_50);
        check("mid_busy", 32'(busy_a), 1);
        reset = 1'b1;
        @(negedge CLOCK_50);
        check("mid_rst_wren", 32'({s_wren_a, ram_wren_a}), 0);
        check("mid_rst_busy_done", 32'({busy_a, done_a}), 0);
        reset = 1'b0;
        wr = 0;
        for (int t = 0; t < 400; t++) begin
            @(negedge CLOCK_50);
            if (s_wren_a || ram_wren_a) wr++;
        end
        check("mid_rst_no_wr", 32'(wr), 0);
        prep(0, 1);
        start_a = 1'b1;
        run(0, 400);
        check("rerun_done_cycle", 32'(cyc), 288);
        @(negedge CLOCK_50);
        cmp_ram_a("rerun_ram");

        // start held high across the run and through DONE
        load_identity(); prep(0, 1); ref_prga(32);
        start_a = 1'b1;
        @(negedge CLOCK_50);
        run(1, 400);
        check("hold_done_cycle", 32'(cyc), 288);
        check("hold_wr_count", 32'(wr_cnt), 32);
        for (int x = 0; x < 32; x++) rom_img[x] = ~rom_img[x];
        load_identity(); ref_prga(32);
        prep(0, 0);
        check("hold_reidle", 32'({busy_a, done_a}), 0);
        run(1, 400);
        check("hold_done_cycle2", 32'(cyc), 288);
        check("hold_wr_count2", 32'(wr_cnt), 32);
        start_a = 1'b0;
        @(negedge CLOCK_50);
        check("hold_stay_done", 32'(done_a), 1);
        cmp_ram_a("hold_ram");

        // 300-byte instance, identity S: i wraps 255 -> 0
        sel = 1'b1;
        rom_img[0] = 8'hFF; rom_img[1] = 8'hFF; rom_img[2] = 8'hFF;
        load_identity(); prep(1, 1); ref_prga(300);
        start_b = 1'b1;
        run(0, 3000);
        check("long_done_cycle", 32'(cyc), 2700);
        check("long_wr_count", 32'(wr_cnt), 300);
        check("long_wr_order", 32'(ord_err), 0);
        @(negedge CLOCK_50);
        check("long_ram0", 32'(ram_b[0]), 'hFD);
        check("long_ram1", 32'(ram_b[1]), 'hFA);
        check("long_ram2", 32'(ram_b[2]), 'hF8);
        mism = 0;
        for (int kk = 0; kk < 300; kk++) if (ram_b[kk] !== exp_dec[kk]) mism++;
        check("long_ram_mism", 32'(mism), 0);
        check("long_busy_done", 32'({busy_b, done_b}), 'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rc4_prga_decrypt.md
Name: rc4_prga_decrypt

Overview:
RC4 pseudo-random generation and decryption stage. It sits directly downstream of the key-scheduling stage and runs once key scheduling has finished permuting the 256x8 S memory. It walks the PRGA over S, producing one keystream byte per message byte. Each keystream byte is XORed with the matching encrypted-ROM byte and the result is written to the decrypted-message RAM. Access to the S memory is granted by the top-level mux while `busy`=1.

Parameters:
- MSG_LENGTH, 32, number of message bytes processed per run (1..511).
- MSG_ADDR_W, 5, width of the ROM/RAM address; must satisfy 2^MSG_ADDR_W >= MSG_LENGTH.

Ports:
- CLOCK_50  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level, sampled in IDLE; high means S is valid (KSA done).
- s_address  out  8  S memory address.
- s_data  out  8  S memory write data.
- s_wren  out  1  S memory write enable.
- s_q  in  8  S memory read data; 1-cycle registered read, same as s_memory.
- rom_address  out  MSG_ADDR_W  encrypted ROM address.
- rom_q  in  8  encrypted byte; 1-cycle registered read.
- ram_address  out  MSG_ADDR_W  decrypted RAM address.
- ram_data  out  8  decrypted byte.
- ram_wren  out  1  decrypted RAM write enable.
- busy  out  1  high from start acceptance until DONE; owns S memory while high.
- done  out  1  high in DONE.

Behaviour:
- Reset values:
  - All outputs 0.
  - i, j, k counters 0.
  - State IDLE.
  - S memory contents are not restored; key scheduling must rerun before the next start.
- Algorithm, for k = 0..MSG_LENGTH-1:
  - i = (i+1) mod 256
  - j = (j+S[i]) mod 256
  - swap S[i], S[j]
  - f = S[(S[i]+S[j]) mod 256]
  - dec[k] = f XOR enc[k]
- Arithmetic width: i, j and the f-address are 8-bit with natural wrap. k is MSG_ADDR_W+1 bits.
- Output timing: all outputs are registered. The memory captures the address/data/wren set by a state on the following edge. Each wait state absorbs the 1-cycle read latency.
- FSM states and transitions:
  - IDLE: start=1 -> READ_SI, busy<=1. Otherwise stay.
  - READ_SI: i<=i+1; s_address<=i+1; s_wren<=0.
  - WAIT_SI: no action.
  - READ_SJ: si<=s_q; j<=j+s_q; s_address<=j+s_q.
  - WAIT_SJ: no action.
  - WRITE_SI: sj<=s_q; s_address<=i; s_data<=s_q; s_wren<=1.
  - WRITE_SJ: s_address<=j; s_data<=si; s_wren<=1.
  - READ_F: s_wren<=0; s_address<=si+sj; rom_address<=k.
  - WAIT_F: no action.
  - WRITE_OUT: ram_address<=k; ram_data<=s_q^rom_q; ram_wren<=1 for exactly one cycle; k<=k+1.
    - Then -> READ_SI if k+1 < MSG_LENGTH.
    - Otherwise -> DONE.
  - DONE: done=1, busy=0, all wrens 0. start=1 -> IDLE, clearing i, j, k and done.
- Throughput: 9 cycles per byte. done rises 9*MSG_LENGTH cycles after the edge that accepted start (288 cycles for the default).
- Ordering rule: the write to S[i] precedes the write to S[j], and the f read is issued after both. When i==j, both writes go to the same address with the same value, which is legal and must not corrupt S.
- start while busy: ignored.
- reset mid-run: IDLE next cycle, all wrens drop the same cycle, no further writes.

Decomposition:
- Package rc4_pkg:
  - prga_state_t enum.
  - S_DEPTH=256, S_ADDR_W=8.
  - Shared by the key-scheduling FSM and the top-level S mux.
- No sub-module. The S memory, ROM, RAM and ownership mux live in the top level.

Test Plan:
- Identity S (S[x]=x, no KSA), enc[0..2]=FF, start:
  - keystream 02, 05, 07.
  - RAM[0..2]=FD, FA, F8.
  - S[3]=05, S[5]=02 afterwards.
  - First S writes are (addr1, data01) then (addr1, data01), covering i==j.
- Default MSG_LENGTH=32, start pulse at cycle 0:
  - done rises at cycle 288.
  - exactly 32 ram_wren pulses at addresses 0..31, ascending.
  - busy is 0 after.
- Key 00_02_49 via KSA, then this block, against a bench reference model: all 32 RAM bytes match the model.
- Reset asserted at cycle 100:
  - next cycle all wrens=0, busy=0, done=0.
  - no RAM writes after.
  - rerun of KSA + start gives the correct result.
- start held high throughout the run: no restart mid-run. In DONE, start re-enters IDLE and reruns with i=j=0.
- MSG_LENGTH=300, MSG_ADDR_W=9, identity S: i wraps 255->0 without stall, and results match the model for all 300 bytes.
